pc_unit: RTL
============

Name: pc_unit

Overview:
- Parametrised program-counter unit for the console CPU datapath. It is the next generation of the basic PC register.
- Keeps byte-wise PCL/PCH loads and increment. Adds configurable address width, reset vector, and native 6502-style relative branching with a two-cycle page-cross fixup FSM.
- Sits between the ALU output / memory read bus and the address mux.
- Its busy output tells the CPU control unit to stall microcode during a fixup cycle.

Parameters:
- ADDR_W, 16, PC width in bits; legal range 9..16. PCL is [7:0]; PCH is [ADDR_W-1:8].
- RESET_PC, 16'h0000, value loaded on reset, truncated to ADDR_W bits.
- TRACE_DEPTH, 4, jump-trace buffer depth; power of two, 2..16. Used only with PC_TRACE_EN.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  reset, synchronous, active-high.
- cpu_en  in  1  CPU clock enable. All state holds when low.
- wd0  in  8  write data 0 (ALU result).
- wd1  in  8  write data 1 (memory read data).
- pcl_src  in  1  PCL source select: 0 = wd0, 1 = wd1.
- pch_src  in  1  PCH source select: 0 = wd0, 1 = wd1.
- pcl_write  in  1  load PCL.
- pch_write  in  1  load PCH from the low ADDR_W-8 bits of the selected byte.
- pc_inc  in  1  increment PC.
- br_take  in  1  apply relative branch.
- br_off  in  8  signed two's-complement branch offset.
- pc_out  out  ADDR_W  current PC (registered).
- busy  out  1  high while the FSM is in FIXUP.
- fix_dir  out  1  valid when busy: 1 = PCH will decrement, 0 = PCH will increment.

Behaviour:
- Reset: pc_out = RESET_PC, state = IDLE, busy = 0, fix_dir = 0. Reset overrides cpu_en. Reset during FIXUP aborts the fixup.
- cpu_en = 0: PC, FSM state and fix_dir all hold; every command is ignored.
- IDLE, commands evaluated with cpu_en = 1, in priority order:
  - pc_inc: pc <= pc + 1, full ADDR_W width, wrapping all-ones to 0.
  - br_take: sum9 = {0,PCL} + {0,br_off}; PCL <= sum9[7:0]; crossed = sum9[8] XOR br_off[7].
    - If crossed: state -> FIXUP, fix_dir <= br_off[7].
    - If not crossed: stay in IDLE; the branch completes in one cycle.
  - pcl_write / pch_write: independent byte loads. Both may assert together. Each is ignored when pc_inc or br_take is high.
- FIXUP:
  - On the next cpu_en cycle: PCH <= PCH + 1 if fix_dir = 0, else PCH - 1, modulo 2^(ADDR_W-8). State -> IDLE.
  - pc_inc, br_take, pcl_write and pch_write are all ignored while in FIXUP. Control must not issue commands while busy is high.
  - busy = (state == FIXUP), decoded from a registered state, so no combinational path from the inputs.
- Branch latency:
  - No page cross: new PC visible the cycle after br_take.
  - Page cross: PCL is correct after 1 cycle; the full PC is correct after 2 enabled cycles.
- Offset boundaries:
  - br_off = 0x00 never crosses.
  - br_off = 0x80 from PCL = 0x80 gives PCL 0x00, carry = 1, XOR sign = 0, so no cross (same page). This is correct 6502 behaviour.
- Wrap: PCH fixup at the all-ones page wraps to page 0, and at page 0 backward wraps to the all-ones page. There is no flag.

Optional Feature:
- Macro: PC_TRACE_EN.
- Defined, the module adds a jump-trace ring buffer of TRACE_DEPTH entries × ADDR_W bits, with ports:
  - trace_idx  in  $clog2(TRACE_DEPTH)  read index; 0 = newest entry.
  - trace_pc  out  ADDR_W  selected entry, combinational read.
  - trace_cnt  out  $clog2(TRACE_DEPTH)+1  number of valid entries; saturates at TRACE_DEPTH.
- Capture: every accepted br_take or accepted pcl/pch write pushes the pre-update PC. A FIXUP cycle does not push. The oldest entry is overwritten when full.
- Reset clears trace_cnt to 0. Buffer contents are don't-care after reset. trace_pc is 0 when trace_idx >= trace_cnt.
- Undefined: trace ports and storage are absent; all other behaviour is identical.

Test Plan:
- Reset with RESET_PC = 16'hFFFC, then 3 × pc_inc -> pc_out sequence FFFC, FFFD, FFFE, FFFF; a 4th pc_inc gives 0000.
- PC = 0x12F0, br_take, br_off = 0x20 -> next cycle pc_out = 0x1210, busy = 1, fix_dir = 0; following cycle pc_out = 0x1310, busy = 0.
- PC = 0x1205, br_off = 0xF0 (-16) -> 0x12F5, busy = 1, fix_dir = 1; then 0x11F5. Repeat from PC = 0x1240 -> 0x1230 with busy never high.
- In FIXUP, pulse pcl_write (wd0 = 0xAA) together with cpu_en = 0 for 2 cycles -> PC and busy hold. Then cpu_en = 1 -> fixup completes and PCL stays unchanged by 0xAA.
- pcl_write + pch_write with pcl_src = 1, pch_src = 0, wd1 = 0x34, wd0 = 0x56 -> pc_out = 0x5634. Same cycle with pc_inc = 1 -> pc_out = old PC + 1 only.
- PC_TRACE_EN, TRACE_DEPTH = 4: 5 jumps from PCs A..E -> trace_cnt = 4; trace_idx 0..3 reads E, D, C, B. Reset -> trace_cnt = 0.

Source files
------------

// File: rtl/pc_unit.sv
// Program-counter unit: byte-wise PCL/PCH loads, increment, relative branch with page-cross fixup.
// Latency: every command lands in pc_out one enabled cycle later; a page-crossing branch needs one more enabled cycle.
// Backpressure: busy is high during the fixup cycle and the control unit must stall. cpu_en low freezes all state.
//
// Optional feature macro: PC_TRACE_EN (adds a jump-trace ring buffer).
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   cpu_en              clock enable; all state holds when low
//   wd0, wd1            write data (ALU result, memory read data)
//   pcl_src, pch_src    byte source selects (0 = wd0, 1 = wd1)
//   pcl_write/pch_write byte loads
//   pc_inc              increment the full PC
//   br_take, br_off     relative branch, signed 8-bit offset
//   pc_out              registered PC
//   busy, fix_dir       fixup in progress; direction (1 = PCH decrements)
//   trace_idx/pc/cnt    (PC_TRACE_EN only) trace read index, entry, valid count
module pc_unit #(
  parameter int          ADDR_W      = 16,
  parameter logic [15:0] RESET_PC    = 16'h0000,
  parameter int          TRACE_DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           cpu_en,
  input  logic [7:0]                     wd0,
  input  logic [7:0]                     wd1,
  input  logic                           pcl_src,
  input  logic                           pch_src,
  input  logic                           pcl_write,
  input  logic                           pch_write,
  input  logic                           pc_inc,
  input  logic                           br_take,
  input  logic [7:0]                     br_off,
`ifdef PC_TRACE_EN
  input  logic [$clog2(TRACE_DEPTH)-1:0] trace_idx,
  output logic [ADDR_W-1:0]              trace_pc,
  output logic [$clog2(TRACE_DEPTH):0]   trace_cnt,
`endif
  output logic [ADDR_W-1:0]              pc_out,
  output logic                           busy,
  output logic                           fix_dir
);

  localparam int                PCH_W   = ADDR_W - 8;
  localparam logic [ADDR_W-1:0] RST_PC  = RESET_PC[ADDR_W-1:0];
  localparam logic [ADDR_W-1:0] PC_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [PCH_W-1:0]  PCH_ONE = {{(PCH_W-1){1'b0}}, 1'b1};

  typedef enum logic {IDLE, FIXUP} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              fix_q, fix_d;
  logic              push;
  logic [8:0]        sum9;
  logic [7:0]        sel_l, sel_h;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= RST_PC;
      fix_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      fix_q   <= fix_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    fix_d   = fix_q;
    push    = 1'b0;
    sum9    = {1'b0, pc_q[7:0]} + {1'b0, br_off};
    sel_l   = pcl_src ? wd1 : wd0;
    sel_h   = pch_src ? wd1 : wd0;
    if (cpu_en) begin
      case (state_q)
        IDLE: begin
          if (pc_inc) begin
            pc_d = pc_q + PC_ONE;
          end else if (br_take) begin
            pc_d[7:0] = sum9[7:0];
            push      = 1'b1;
            // Carry out of PCL disagreeing with the offset sign means the
            // target lies on the neighbouring page.
            if (sum9[8] ^ br_off[7]) begin
              state_d = FIXUP;
              fix_d   = br_off[7];
            end
          end else begin
            if (pcl_write) pc_d[7:0] = sel_l;
            if (pch_write) pc_d[ADDR_W-1:8] = sel_h[PCH_W-1:0];
            push = pcl_write | pch_write;
          end
        end
        FIXUP: begin
          pc_d[ADDR_W-1:8] = fix_q ? (pc_q[ADDR_W-1:8] - PCH_ONE)
                                   : (pc_q[ADDR_W-1:8] + PCH_ONE);
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign pc_out  = pc_q;
  assign busy    = (state_q == FIXUP);
  assign fix_dir = fix_q;

`ifdef PC_TRACE_EN
  localparam int              TW      = $clog2(TRACE_DEPTH);
  localparam logic [TW:0]     DEPTH_C = (TW+1)'(TRACE_DEPTH);
  localparam logic [TW-1:0]   PTR_ONE = TW'(1);

  logic [ADDR_W-1:0] tbuf [TRACE_DEPTH];
  logic [TW-1:0]     wptr;
  logic [TW:0]       cnt;
  logic [TW-1:0]     rptr;

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr <= '0;
      cnt  <= '0;
    end else if (push) begin
      wptr <= wptr + PTR_ONE;
      if (cnt != DEPTH_C) cnt <= cnt + 1'b1;
    end
  end

  // Storage needs no reset: entries beyond cnt are masked on read.
  always_ff @(posedge clk) begin
    if (!reset && push) tbuf[wptr] <= pc_q;
  end

  // Newest entry sits just behind the write pointer.
  assign rptr      = wptr - PTR_ONE - trace_idx;
  assign trace_pc  = ({1'b0, trace_idx} < cnt) ? tbuf[rptr] : '0;
  assign trace_cnt = cnt;
`endif

endmodule
